spi_rx: RTL and testbench
=========================

# spi_rx

SPI mode-0 (CPOL=0, CPHA=0) slave-side receiver: the far end of the team's 16-bit MSB-first SPI master transmitter. Oversamples `spi_cs_L`, `spi_sclk` and `spi_data` on the local `clk` and shifts in one bit per SCLK rising edge. Presents each complete word on a valid/ready holding register. Sits between the SPI pins and any local consumer (register file, FIFO).

## Interface
- `WIDTH`, default 16: bits per word; must be 2..31.
- `CNT_W`, default 5: width of `counter`; must satisfy 2^CNT_W > WIDTH.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset_L`  in  1  reset, asynchronous and active-low.
- `spi_cs_L`  in  1  chip select, active low; the SCLK domain may be unrelated to `clk`.
- `spi_sclk`  in  1  serial clock, idle low.
- `spi_data`  in  1  MOSI, valid on SCLK rise.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid` is high.
- `rx_data`  out  WIDTH  last complete word, MSB first on the wire.
- `rx_valid`  out  1  `rx_data` holds an unconsumed word.
- `rx_overrun`  out  1  one-cycle pulse: completed word dropped because the holding register was full.
- `frame_err`  out  1  one-cycle pulse: CS deasserted mid-word. Only driven with `SPI_RX_FRAME_ERR_EN`, else tied 0.
- `counter`  out  CNT_W  bits received in the current word, 0..WIDTH-1.

## Operation
- Each SPI input passes through a 2-flop synchronizer.
  - Reset values: cs=1, sclk=0, data=0.
  - A third flop on sclk gives `sclk_rise` = s2 & ~s3.
- FSM states:
  - RESYNC (reset state) → IDLE when synced cs=1. A frame already in flight at reset release is ignored.
  - IDLE → SHIFT when synced cs=0; `counter` is cleared on entry.
  - SHIFT, on `sclk_rise`: shift register ← {sr[WIDTH-2:0], synced data}; `counter` +1.
  - SHIFT, when the bit taken is bit WIDTH-1 (`counter`==WIDTH-1): word complete and `counter` → 0. Stay in SHIFT, so back-to-back words with CS held low are legal.
  - SHIFT → IDLE when synced cs=1. Any partial word is discarded and `counter` → 0.
- Holding register on word complete:
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 in the same cycle: load `rx_data`; `rx_valid`=1.
  - If `rx_valid`=1 with `rx_ready`=0: keep the old word, drop the new one, pulse `rx_overrun`.
- Handshake: `rx_valid` & `rx_ready` with no completion that cycle → `rx_valid` falls next cycle.
- CS rise and the final SCLK rise are never simultaneous after synchronization for a compliant master. If they coincide, the completion is processed first, then IDLE.

## Timing
- Reset values of outputs: `rx_data`=0, `rx_valid`=0, `rx_overrun`=0, `frame_err`=0, `counter`=0. FSM starts in RESYNC.
- SCLK high and low phases must each last ≥1 `clk` period if SCLK is synchronous to `clk`, or ≥2 periods if asynchronous. The team master (1 clk low, 1 clk high) is therefore supported when it shares `clk`.
- Latency, with T = first `clk` edge at which the pin `spi_sclk` is high for bit WIDTH-1:
  - shift register holds the full word at T+2;
  - `rx_data`/`rx_valid` update at T+3.
- `counter` increments 2 edges after the pin-level SCLK rise.
- CS high must last ≥2 `clk` periods to be seen. The master's 1-cycle CS-high gap is seen only when it shares `clk`.
- `rx_overrun` and `frame_err` are high for exactly one cycle.
- Asserting `reset_L` mid-word clears everything asynchronously; that word is lost.

## Configuration
- `SPI_RX_FRAME_ERR_EN` defined:
  - SHIFT → IDLE with `counter`≠0 pulses `frame_err` for one cycle, in the same cycle the FSM enters IDLE.
  - RESYNC exit never pulses it.
- `SPI_RX_FRAME_ERR_EN` undefined: `frame_err` is constant 0 and partial words are discarded silently. All other behaviour is identical.

## Structure
- Package `spi_pkg` holds:
  - `SPI_WORD_W` = 16, the shared default for master and receiver;
  - `SPI_CNT_W` = 5;
  - the FSM state enum `spi_rx_state_t` {RESYNC, IDLE, SHIFT}.
- Sub-module `spi_sync`: a parameterised 2-flop synchronizer with a reset-value parameter, instantiated three times. Edge detect stays in `spi_rx`.

## Test plan
- Master sends 16'hA5C3 and 16'h0001, CS high between words, `rx_ready`=1 → two `rx_valid` beats with `rx_data` A5C3 then 0001; `counter` returns to 0 after each word.
- `rx_ready`=0 while two words 16'h1234 and 16'h5678 arrive → `rx_data` stays 1234 and one `rx_overrun` pulse occurs. Raising `rx_ready` drops `rx_valid` on the next cycle.
- `rx_ready`=1 exactly in the completion cycle of a second word 16'hBEEF → `rx_valid` stays high, `rx_data`=BEEF, no overrun.
- CS raised after 7 bits of 16'hFFFF, then full word 16'h00FF sent → the partial is discarded and `rx_data`=00FF.
  - With the macro: `frame_err` pulses once.
  - Without the macro: `frame_err` stays 0.
- `reset_L` pulsed low after 9 bits with CS held low; remaining bits still clocked → no word delivered and `counter`=0 until CS goes high. The next full word 16'h8001 is received correctly.
- Back-to-back words 16'hCAFE and 16'hF00D with CS held low, SCLK low/high 2 clk each, `rx_ready`=1 → both words delivered; `rx_valid` rises 3 clk edges after the final SCLK rise of each word.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI word/counter widths and the receiver FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_CNT_W  = 5;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        SHIFT  = 2'd2
    } spi_rx_state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous pin, with a selectable reset value.
// Latency: 2 clk edges from pin to q.
// Backpressure: none.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_L,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver, MSB first; word presented on a valid/ready holding register.
// Latency: rx_valid/rx_data update 3 clk edges after the first edge that sees the last SCLK high.
// Backpressure: holding register full at completion -> new word dropped, rx_overrun pulses.
// Optional: define SPI_RX_FRAME_ERR_EN to pulse frame_err when CS rises mid-word.
module spi_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             spi_cs_L,
    input  logic             spi_sclk,
    input  logic             spi_data,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_overrun,
    output logic             frame_err,
    output logic [CNT_W-1:0] counter
);

    logic cs_s;
    logic sclk_s;
    logic data_s;

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .reset_L(reset_L), .d(spi_cs_L), .q(cs_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .reset_L(reset_L), .d(spi_sclk), .q(sclk_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_data (.clk(clk), .reset_L(reset_L), .d(spi_data), .q(data_s));

    spi_rx_state_t    state_q,    state_d;
    logic [WIDTH-1:0] sr_q,       sr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             done_q,     done_d;
    logic [1:0]       settle_q,   settle_d;
    logic             sclk_s3_q;
    logic [WIDTH-1:0] rx_data_q,  rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q,  overrun_d;
`ifdef SPI_RX_FRAME_ERR_EN
    logic             ferr_q,     ferr_d;
`endif

    logic sclk_rise;
    logic last_bit;

    assign sclk_rise = sclk_s & ~sclk_s3_q;
    assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state: FSM, shifter, bit counter and holding register.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        settle_d   = {settle_q[0], 1'b1};
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
        ferr_d     = 1'b0;
`endif

        case (state_q)
            // Synced CS reads its reset value (1) for two cycles after reset;
            // wait for real pin data so a frame in flight is not mistaken for idle.
            RESYNC: begin
                if (settle_q[1] && cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!cs_s) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    sr_d = {sr_q[WIDTH-2:0], data_s};
                    if (last_bit) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // Completion above wins over a coincident CS rise.
                if (cs_s) begin
                    state_d = IDLE;
`ifdef SPI_RX_FRAME_ERR_EN
                    ferr_d  = (cnt_d != '0);
`endif
                    cnt_d   = '0;
                end
            end
            default: state_d = RESYNC;
        endcase

        if (done_q) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = sr_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= RESYNC;
            sr_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            settle_q   <= 2'b00;
            sclk_s3_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            ferr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            settle_q   <= settle_d;
            sclk_s3_q  <= sclk_s;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
`ifdef SPI_RX_FRAME_ERR_EN
            ferr_q     <= ferr_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = overrun_q;
    assign counter    = cnt_q;
`ifdef SPI_RX_FRAME_ERR_EN
    assign frame_err  = ferr_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: table of single-word frames plus hand-written corner sequences.
// Inputs change 1 time unit after posedge; outputs are checked 1 time unit after negedge.
// Expected values are hand-written constants per vector/sequence.
module tb_spi_rx;

    logic        clk;
    logic        reset_L;
    logic        spi_cs_L;
    logic        spi_sclk;
    logic        spi_data;
    logic        rx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_overrun;
    logic        frame_err;
    logic [4:0]  counter;

    spi_rx #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .spi_cs_L   (spi_cs_L),
        .spi_sclk   (spi_sclk),
        .spi_data   (spi_data),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_overrun (rx_overrun),
        .frame_err  (frame_err),
        .counter    (counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Observed events, collected away from the active edge.
    logic [15:0] acc_q[$];
    int          valid_rise_q[$];
    int          ovr_cnt  = 0;
    int          ferr_cnt = 0;
    logic        valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_L) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (rx_overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (rx_valid && !valid_prev) valid_rise_q.push_back(cyc);
        end
        valid_prev = rx_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Send the top nbits of w, MSB first; SCLK low then high for ph clk each; ends with SCLK low.
    task automatic send_bits(input logic [15:0] w, input int nbits, input int ph);
        for (int i = 0; i < nbits; i++) begin
            spi_data = w[15-i];
            spi_sclk = 1'b0;
            ticks(ph);
            spi_sclk = 1'b1;
            ticks(ph);
        end
        spi_sclk = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w, input int ph);
        spi_cs_L = 1'b0;
        ticks(4);
        send_bits(w, 16, ph);
        ticks(6);
        spi_cs_L = 1'b1;
        ticks(4);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    int          n_acc;
    int          n_ovr;
    int          n_ferr;
    int          rise_at[2];
    logic [31:0] stream;

    initial begin
        vecs[0] = '{16'hA5C3, 16'hA5C3};
        vecs[1] = '{16'h0001, 16'h0001};
        vecs[2] = '{16'hFFFF, 16'hFFFF};
        vecs[3] = '{16'h0000, 16'h0000};
        vecs[4] = '{16'h8001, 16'h8001};
        vecs[5] = '{16'h5A5A, 16'h5A5A};

        reset_L  = 1'b0;
        spi_cs_L = 1'b1;
        spi_sclk = 1'b0;
        spi_data = 1'b0;
        rx_ready = 1'b1;
        ticks(3);
        mid();
        check("reset rx_data",    32'(rx_data),    32'h0);
        check("reset rx_valid",   32'(rx_valid),   32'h0);
        check("reset rx_overrun", 32'(rx_overrun), 32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset counter",    32'(counter),    32'h0);
        tick();
        reset_L = 1'b1;
        ticks(6);

        // Table: one word per CS frame, consumer always ready.
        for (int v = 0; v < 6; v++) begin
            n_acc = acc_q.size();
            spi_cs_L = 1'b0;
            ticks(4);
            send_bits(vecs[v].word, 16, 1);
            ticks(6);
            mid();
            check("word counter wraps", 32'(counter), 32'h0);
            check("word beats", 32'(acc_q.size() - n_acc), 32'd1);
            if (acc_q.size() > n_acc) check("word data", 32'(acc_q[$]), 32'(vecs[v].exp_data));
            spi_cs_L = 1'b1;
            ticks(4);
            mid();
            check("word valid drained", 32'(rx_valid), 32'h0);
        end

        // Overrun: consumer stalled across two words.
        n_ovr = ovr_cnt;
        rx_ready = 1'b0;
        tick();
        frame(16'h1234, 1);
        frame(16'h5678, 1);
        mid();
        check("ovr rx_data kept", 32'(rx_data), 32'h1234);
        check("ovr rx_valid", 32'(rx_valid), 32'h1);
        check("ovr pulses", 32'(ovr_cnt - n_ovr), 32'd1);
        tick();
        rx_ready = 1'b1;
        tick();
        mid();
        check("ovr valid drop", 32'(rx_valid), 32'h0);
        check("ovr accepted", 32'(acc_q[$]), 32'h1234);

        // Ready raised only in the completion cycle of the second word.
        n_ovr = ovr_cnt;
        rx_ready = 1'b0;
        tick();
        frame(16'h1111, 1);
        spi_cs_L = 1'b0;
        ticks(4);
        send_bits(16'hBEEF, 16, 1);
        ticks(2);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        mid();
        check("same-cycle valid", 32'(rx_valid), 32'h1);
        check("same-cycle data", 32'(rx_data), 32'hBEEF);
        check("same-cycle no ovr", 32'(ovr_cnt - n_ovr), 32'd0);
        check("same-cycle old acc", 32'(acc_q[$]), 32'h1111);
        spi_cs_L = 1'b1;
        rx_ready = 1'b1;
        ticks(4);

        // Partial word aborted by CS, then a full word.
        n_ferr = ferr_cnt;
        n_acc  = acc_q.size();
        spi_cs_L = 1'b0;
        ticks(4);
        send_bits(16'hFFFF, 7, 1);
        ticks(3);
        mid();
        check("partial counter", 32'(counter), 32'd7);
        tick();
        spi_cs_L = 1'b1;
        ticks(4);
        mid();
        check("partial counter clr", 32'(counter), 32'h0);
        check("partial no beat", 32'(acc_q.size() - n_acc), 32'd0);
        frame(16'h00FF, 1);
        check("after partial data", 32'(acc_q[$]), 32'h00FF);
`ifdef SPI_RX_FRAME_ERR_EN
        check("frame_err pulses", 32'(ferr_cnt - n_ferr), 32'd1);
`else
        check("frame_err pulses", 32'(ferr_cnt - n_ferr), 32'd0);
`endif

        // Reset mid-word with CS held low.
        n_acc = acc_q.size();
        spi_cs_L = 1'b0;
        ticks(4);
        send_bits(16'hABCD, 9, 1);
        ticks(3);
        mid();
        check("pre-reset counter", 32'(counter), 32'd9);
        tick();
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        send_bits(16'hABCD << 9, 7, 1);
        ticks(4);
        mid();
        check("post-reset counter", 32'(counter), 32'h0);
        check("post-reset valid", 32'(rx_valid), 32'h0);
        check("post-reset no beat", 32'(acc_q.size() - n_acc), 32'd0);
        tick();
        spi_cs_L = 1'b1;
        ticks(4);
        frame(16'h8001, 1);
        check("post-reset word", 32'(acc_q[$]), 32'h8001);

        // Back-to-back words, CS held low, SCLK 2/2; latency to rx_valid.
        n_acc = acc_q.size();
        valid_rise_q.delete();
        stream = {16'hCAFE, 16'hF00D};
        spi_cs_L = 1'b0;
        ticks(4);
        for (int i = 0; i < 32; i++) begin
            spi_data = stream[31-i];
            spi_sclk = 1'b0;
            ticks(2);
            spi_sclk = 1'b1;
            if (i == 15) rise_at[0] = cyc;
            if (i == 31) rise_at[1] = cyc;
            ticks(2);
        end
        spi_sclk = 1'b0;
        ticks(6);
        mid();
        check("b2b beats", 32'(acc_q.size() - n_acc), 32'd2);
        if (acc_q.size() - n_acc == 2) begin
            check("b2b first", 32'(acc_q[n_acc]), 32'hCAFE);
            check("b2b second", 32'(acc_q[n_acc+1]), 32'hF00D);
        end
        check("b2b valid rises", 32'(valid_rise_q.size()), 32'd2);
        if (valid_rise_q.size() == 2) begin
            check("b2b latency 1", 32'(valid_rise_q[0] - rise_at[0]), 32'd4);
            check("b2b latency 2", 32'(valid_rise_q[1] - rise_at[1]), 32'd4);
        end
        spi_cs_L = 1'b1;
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
